// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package mul_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // {acc_lo[0], E} encodings that select an operation on the upper accumulator
  localparam logic [1:0] BOOTH_SUB = 2'b10;
  localparam logic [1:0] BOOTH_ADD = 2'b01;

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth iteration: conditional add/sub of Y, then arithmetic shift right.
module booth_step
  import mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic             e,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH:0]   acc_hi_nx,
  output logic [WIDTH-1:0] acc_lo_nx,
  output logic             e_nx
);

  logic [WIDTH:0] w_y_ext;
  logic [WIDTH:0] w_sum;

  // One extra bit keeps -(-2^(WIDTH-1)) representable
  assign w_y_ext = {y[WIDTH-1], y};

  always_comb begin
    w_sum = acc_hi;
    case ({acc_lo[0], e})
      BOOTH_SUB: w_sum = acc_hi + (~w_y_ext) + {{WIDTH{1'b0}}, 1'b1};
      BOOTH_ADD: w_sum = acc_hi + w_y_ext;
      default:   w_sum = acc_hi;
    endcase
  end

  assign acc_hi_nx = {w_sum[WIDTH], w_sum[WIDTH:1]};
  assign acc_lo_nx = {w_sum[0], acc_lo[WIDTH-1:1]};
  assign e_nx      = acc_lo[0];

endmodule

// File: rtl/booth_mul_seq_ctrl.sv
// Sequential signed Booth multiplier: start/ready handshake, one step per clock, registered HI/LO result.
module booth_mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] mplier,
  input  logic [WIDTH-1:0] mcand,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z_high,
  output logic [WIDTH-1:0] z_low
);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH:0]   r_acc_hi;
  logic [WIDTH-1:0] r_acc_lo;
  logic             r_e;
  logic [WIDTH-1:0] r_y;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_z_high;
  logic [WIDTH-1:0] r_z_low;

  logic [WIDTH:0]   w_acc_hi_nx;
  logic [WIDTH-1:0] w_acc_lo_nx;
  logic             w_e_nx;
  logic             w_accept;
  logic             w_last;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc_hi    (r_acc_hi),
    .acc_lo    (r_acc_lo),
    .e         (r_e),
    .y         (r_y),
    .acc_hi_nx (w_acc_hi_nx),
    .acc_lo_nx (w_acc_lo_nx),
    .e_nx      (w_e_nx)
  );

  assign w_accept = (r_state == IDLE) && start && !abort;
  assign w_last   = (r_count == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = RUN;
      RUN: begin
        if (abort)       w_state_next = IDLE;
        else if (w_last) w_state_next = DONE;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_e      <= 1'b0;
      r_y      <= '0;
      r_count  <= '0;
      r_z_high <= '0;
      r_z_low  <= '0;
    end else if (w_accept) begin
      r_acc_hi <= '0;
      r_acc_lo <= mplier;
      r_e      <= 1'b0;
      r_y      <= mcand;
      r_count  <= '0;
    end else if (r_state == RUN && !abort) begin
      r_acc_hi <= w_acc_hi_nx;
      r_acc_lo <= w_acc_lo_nx;
      r_e      <= w_e_nx;
      r_count  <= r_count + 1'b1;
      // Result commits from the post-shift values of the final step
      if (w_last) begin
        r_z_high <= w_acc_hi_nx[WIDTH-1:0];
        r_z_low  <= w_acc_lo_nx;
      end
    end
  end

  assign ready  = (r_state == IDLE);
  assign busy   = (r_state == RUN) || (r_state == DONE);
  assign done   = (r_state == DONE);
  assign z_high = r_z_high;
  assign z_low  = r_z_low;

endmodule

// File: tb/tb_booth_mul_seq_ctrl.sv
// Randomised self-checking bench: cycle-level behavioural model plus literal product checks.
module tb_booth_mul_seq_ctrl;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  mplier = '0;
  logic [W-1:0]  mcand = '0;
  logic          ready, busy, done;
  logic [W-1:0]  z_high, z_low;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  booth_mul_seq_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .abort  (abort),
    .mplier (mplier),
    .mcand  (mcand),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .z_high (z_high),
    .z_low  (z_low)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] sprod(input logic [W-1:0] a, input logic [W-1:0] b);
    longint pa;
    pa = longint'($signed(a)) * longint'($signed(b));
    return pa;
  endfunction

  // Observable model: 0 idle, 1 computing, 2 result-ready cycle
  int          m_mode = 0;
  int          m_steps = 0;
  logic [63:0] m_prod = '0;
  logic [63:0] m_z = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0;
      m_steps = 0;
      m_z = '0;
    end else begin
      case (m_mode)
        0: if (start && !abort) begin
          m_prod = sprod(mplier, mcand);
          m_steps = 0;
          m_mode = 1;
        end
        1: if (abort) m_mode = 0;
           else begin
             m_steps++;
             if (m_steps == W) begin
               m_z = m_prod;
               m_mode = 2;
             end
           end
        default: m_mode = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    logic [66:0] act, exp;
    act = {ready, busy, done, z_high, z_low};
    exp = {m_mode == 0, m_mode != 0, m_mode == 2, m_z};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL cycle %0d model: got rdy/busy/done=%b%b%b z=%h_%h, want %b%b%b z=%h",
               cyc, ready, busy, done, z_high, z_low, m_mode == 0, m_mode != 0, m_mode == 2, m_z);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Returns after the accepting edge (+1 time unit)
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y);
    @(posedge clk);
    #1;
    start = 1'b1;
    mplier = x;
    mcand = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    mplier = $urandom;
    mcand = $urandom;
  endtask

  // Counts negedges until done is seen; returns at that negedge
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (done) return;
    end
    n_vec++;
    n_err++;
    $display("FAIL wait_done: timeout, done never asserted");
    n = -1;
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, output int lat);
    start_op(x, y);
    wait_done(lat);
  endtask

  initial begin
    int lat, n;
    int c1, c2;
    logic [W-1:0] a, b;
    logic [W-1:0] corners [6];
    corners[0] = 32'h0000_0000;
    corners[1] = 32'h0000_0001;
    corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000;
    corners[4] = 32'h7FFF_FFFF;
    corners[5] = 32'h8000_0001;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {59'd0, ready, busy, done, z_high[0], z_low[0]}, {59'd0, 5'b10000});
    rst_n = 1'b1;

    run_op(32'd7, -32'sd3, lat);
    chk("lat_7x-3", 64'(lat), 64'(W + 1));
    chk("7x-3", {z_high, z_low}, 64'hFFFF_FFFF_FFFF_FFEB);

    run_op(32'h8000_0000, 32'h8000_0000, lat);
    chk("min_x_min", {z_high, z_low}, 64'h4000_0000_0000_0000);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    chk("m1_x_m1", {z_high, z_low}, 64'h0000_0000_0000_0001);

    run_op(32'd5, 32'd6, lat);
    chk("5x6", {z_high, z_low}, 64'd30);
    start_op(32'd3, 32'd4);
    repeat (10) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_ready", {63'd0, ready}, 64'd1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) chk("abort_no_done", 64'd1, 64'd0);
    end
    chk("abort_keeps_z", {z_high, z_low}, 64'd30);
    run_op(32'd3, 32'd4, lat);
    chk("3x4", {z_high, z_low}, 64'd12);

    start_op(32'h0000_1234, 32'hFFFF_FF55);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1;
    mplier = 32'd99;
    mcand = 32'd77;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat);
    chk("start_in_run_ignored", {z_high, z_low}, sprod(32'h0000_1234, 32'hFFFF_FF55));
    start = 1'b1;
    mplier = 32'd11;
    mcand = 32'd13;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("start_in_done_ignored", {62'd0, ready, busy}, 64'b10);

    @(posedge clk);
    #1;
    start = 1'b1;
    mplier = 32'hDEAD_BEEF;
    mcand = 32'h0000_0101;
    wait_done(lat);
    c1 = cyc;
    chk("b2b_first", {z_high, z_low}, sprod(32'hDEAD_BEEF, 32'h0000_0101));
    mplier = 32'h7FFF_FFFF;
    mcand = 32'h8000_0000;
    wait_done(n);
    c2 = cyc;
    start = 1'b0;
    chk("b2b_spacing", 64'(c2 - c1), 64'd34);
    chk("b2b_second", {z_high, z_low}, 64'hC000_0000_8000_0000);

    start_op(32'h1234_5678, 32'h9ABC_DEF0);
    repeat (14) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset", {59'd0, ready, busy, done, 2'b00}, {59'd0, 5'b10000});
    chk("async_reset_z", {z_high, z_low}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_op(32'h1234_5678, 32'h9ABC_DEF0, lat);
    chk("rerun_after_reset", {z_high, z_low}, sprod(32'h1234_5678, 32'h9ABC_DEF0));

    for (int i = 0; i < 1000; i++) begin
      a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      run_op(a, b, lat);
      chk("random_lat", 64'(lat), 64'(W + 1));
    end

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
